// File: rtl/label_sram_pkg.sv
// label_sram_pkg: default widths, FSM states and read-owner tags shared by label_sram_arbiter.
package label_sram_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, SERVE, CLEAR} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_ENG, TAG_HOST} tag_t;
endpackage

// File: rtl/label_sram_grant.sv
// label_sram_grant: engine-priority grant with a saturating host starvation counter.
module label_sram_grant #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic block,
    input  logic e_req,
    input  logic h_req,
    output logic e_gnt,
    output logic h_gnt
);
    logic [7:0] wait_cnt;
    always_comb begin
        h_gnt = reset && !block && h_req && (!e_req || wait_cnt == 8'(MAX_WAIT));
        e_gnt = reset && !block && e_req && !h_gnt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (h_gnt)
            wait_cnt <= '0;
        else if (h_req && wait_cnt != 8'(MAX_WAIT))
            wait_cnt <= wait_cnt + 8'd1;
    end
endmodule

// File: rtl/label_sram_arbiter.sv
// label_sram_arbiter: engine/host SRAM arbiter with tagged read return; LABEL_SRAM_CLEAR_EN adds a zero-fill CLEAR mode.
module label_sram_arbiter
    import label_sram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_req,
    input  logic              e_wen,
    input  logic [ADDR_W-1:0] e_a,
    input  logic [DATA_W-1:0] e_d,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_q,
    input  logic              h_req,
    input  logic              h_wen,
    input  logic [ADDR_W-1:0] h_a,
    input  logic [DATA_W-1:0] h_d,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_q,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_wen,
    input  logic [DATA_W-1:0] sram_q,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);
    state_t state;
    tag_t   tag0, tag1;
    logic   block;
`ifdef LABEL_SRAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_go;
    assign clr_go   = clr_start && state != CLEAR;
    assign block    = clr_go || state == CLEAR;
    assign clr_busy = state == CLEAR;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= state == CLEAR && &clr_cnt;
            if (clr_go)
                clr_cnt <= '0;
            else if (state == CLEAR && !(&clr_cnt))
                clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end
`else
    logic unused_ok;
    assign unused_ok = clr_start | (state == SERVE);
    assign block     = 1'b0;
    assign clr_busy  = 1'b0;
    assign clr_done  = 1'b0;
`endif
    label_sram_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
        .clk   (clk),
        .reset (reset),
        .block (block),
        .e_req (e_req),
        .h_req (h_req),
        .e_gnt (e_gnt),
        .h_gnt (h_gnt)
    );
    // Read data is returned to whoever tag1 names; tag0 marks the cycle sram_q is valid.
    assign e_rvalid = tag1 == TAG_ENG;
    assign h_rvalid = tag1 == TAG_HOST;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sram_a   <= '0;
            sram_d   <= '0;
            sram_wen <= 1'b1;
            tag0     <= TAG_NONE;
            tag1     <= TAG_NONE;
            e_q      <= '0;
            h_q      <= '0;
        end else begin
            tag0     <= (e_gnt && e_wen) ? TAG_ENG : (h_gnt && h_wen) ? TAG_HOST : TAG_NONE;
            tag1     <= tag0;
            sram_wen <= e_gnt ? e_wen : h_gnt ? h_wen : 1'b1;
            state    <= (e_req || h_req) ? SERVE : IDLE;
            if (tag0 == TAG_ENG)
                e_q <= sram_q;
            if (tag0 == TAG_HOST)
                h_q <= sram_q;
            if (e_gnt || h_gnt) begin
                sram_a <= e_gnt ? e_a : h_a;
                sram_d <= e_gnt ? e_d : h_d;
            end
`ifdef LABEL_SRAM_CLEAR_EN
            if (clr_go)
                state <= CLEAR;
            if (state == CLEAR) begin
                sram_a   <= clr_cnt;
                sram_d   <= '0;
                sram_wen <= 1'b0;
                state    <= &clr_cnt ? IDLE : CLEAR;
            end
`endif
        end
    end
endmodule

// File: tb/tb_label_sram_arbiter.sv
// tb_label_sram_arbiter: table, random and directed checks of label_sram_arbiter; clear tests need LABEL_SRAM_CLEAR_EN.
module tb_label_sram_arbiter;
    localparam int MW = 8;
`ifdef LABEL_SRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    logic clk, reset;
    logic e_req, e_wen, h_req, h_wen, clr_start;
    logic [9:0] e_a, h_a, sram_a;
    logic [7:0] e_d, h_d, e_q, h_q, sram_d, sram_q;
    logic e_gnt, e_rvalid, h_gnt, h_rvalid, sram_wen, clr_busy, clr_done;

    label_sram_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .e_req(e_req), .e_wen(e_wen), .e_a(e_a), .e_d(e_d),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_q(e_q),
        .h_req(h_req), .h_wen(h_wen), .h_a(h_a), .h_d(h_d),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_q(h_q),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    // Environment SRAM: write on posedge when sram_wen low, asynchronous read.
    logic [7:0] mem [0:1023];
    assign sram_q = mem[sram_a];
    always @(posedge clk) if (!sram_wen) mem[sram_a] <= sram_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: accesses are serialized in acceptance order; a read returns
    // the memory contents at acceptance, two cycles later, to its own requester.
    logic [7:0] ref_mem [0:1023];
    logic [7:0] due_e [int];
    logic [7:0] due_h [int];
    int waitc, cyc_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        e_req = 1'b0; h_req = 1'b0; e_wen = 1'b1; h_wen = 1'b1;
        e_a = '0; h_a = '0; e_d = '0; h_d = '0; clr_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc_n = 0;
        waitc = 0;
        due_e.delete();
        due_h.delete();
    endtask

    task automatic step(input logic er, input logic hr, input logic ew, input logic hw,
                        input logic [9:0] ea, input logic [9:0] ha,
                        input logic [7:0] ed, input logic [7:0] hd, input logic cs,
                        output logic ge, output logic gh);
        logic xe, xh;
        e_req = er; h_req = hr; e_wen = ew; h_wen = hw;
        e_a = ea; h_a = ha; e_d = ed; h_d = hd; clr_start = cs;
        @(negedge clk);
        xh = hr && (!er || waitc == MW);
        xe = er && !xh;
        ge = e_gnt;
        gh = h_gnt;
        chk("e_gnt", e_gnt, xe);
        chk("h_gnt", h_gnt, xh);
        chk("e_rvalid", e_rvalid, due_e.exists(cyc_n));
        chk("h_rvalid", h_rvalid, due_h.exists(cyc_n));
        if (due_e.exists(cyc_n)) chk("e_q", e_q, due_e[cyc_n]);
        if (due_h.exists(cyc_n)) chk("h_q", h_q, due_h[cyc_n]);
        chk("clr_busy_idle", clr_busy, 1'b0);
        chk("clr_done_idle", clr_done, 1'b0);
        if (xe && !ew) ref_mem[ea] = ed;
        if (xe && ew) due_e[cyc_n + 2] = ref_mem[ea];
        if (xh && !hw) ref_mem[ha] = hd;
        if (xh && hw) due_h[cyc_n + 2] = ref_mem[ha];
        waitc = xh ? 0 : (hr && waitc < MW) ? waitc + 1 : waitc;
        tick();
        cyc_n++;
    endtask

    typedef struct {
        logic er, hr, ew, hw;
        logic [9:0] ea, ha;
        logic [7:0] ed, hd;
        logic xe, xh;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic er, hr, ew, hw, ge, gh, cs;
        logic [9:0] ea, ha;
        logic [7:0] ed, hd;
        int err, busy_err, gnt_err, seq_err, done_cnt, done_at, found;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sram_wen", sram_wen, 1'b1);
        chk("rst_sram_a", sram_a, 10'h0);
        chk("rst_sram_d", sram_d, 8'h0);
        chk("rst_rvalid", {e_rvalid, h_rvalid}, 2'b00);
        chk("rst_q", {e_q, h_q}, 16'h0);
        chk("rst_clr", {clr_busy, clr_done}, 2'b00);

        // Table: consecutive cycles from reset; expected grants worked out by hand.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h0, 10'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h3, 10'h0, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h0, 10'h4, 8'h00, 8'h22, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h5, 10'h6, 8'h33, 8'h44, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h5, 10'h6, 8'h33, 8'h44, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h0, 10'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h0, 10'h3, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h4, 10'h0, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h5, 10'h6, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h0, 10'h6, 8'h00, 8'h00, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].er, tbl[i].hr, tbl[i].ew, tbl[i].hw, tbl[i].ea, tbl[i].ha,
                 tbl[i].ed, tbl[i].hd, 1'b0, ge, gh);
            chk("tbl_e_gnt", ge, tbl[i].xe);
            chk("tbl_h_gnt", gh, tbl[i].xh);
        end

        // Random traffic; requesters hold their access until it is granted.
        er = 1'b0; hr = 1'b0; ge = 1'b0; gh = 1'b0;
        ew = 1'b1; hw = 1'b1; ea = '0; ha = '0; ed = '0; hd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!er || ge) begin
                er = $urandom_range(0, 3) != 0;
                ew = $urandom_range(0, 1) == 1;
                ea = 10'($urandom_range(0, 15));
                ed = 8'($urandom);
            end
            if (!hr || gh) begin
                hr = $urandom_range(0, 3) != 0;
                hw = $urandom_range(0, 1) == 1;
                ha = 10'($urandom_range(0, 15));
                hd = 8'($urandom);
            end
            cs = CLR_EN ? 1'b0 : ($urandom_range(0, 7) == 0);
            step(er, hr, ew, hw, ea, ha, ed, hd, cs, ge, gh);
        end

        // Both requesters saturated: host every 9th cycle.
        do_reset();
        e_req = 1'b1; h_req = 1'b1; e_wen = 1'b0; h_wen = 1'b0;
        err = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (h_gnt !== (i % 9 == 8) || e_gnt !== (i % 9 != 8)) err++;
            tick();
        end
        chk("starve_pattern", err, 0);

        // Engine write then read of 0x21.
        do_reset();
        e_req = 1'b1; e_wen = 1'b0; e_a = 10'h21; e_d = 8'h05;
        @(negedge clk);
        chk("wr_gnt", e_gnt, 1'b1);
        tick();
        e_wen = 1'b1;
        @(negedge clk);
        chk("rd_gnt", e_gnt, 1'b1);
        chk("wr_sram", {sram_wen, sram_a, sram_d}, {1'b0, 10'h21, 8'h05});
        tick();
        e_req = 1'b0;
        @(negedge clk);
        chk("rd_early", e_rvalid, 1'b0);
        chk("rd_sram_wen", sram_wen, 1'b1);
        tick();
        @(negedge clk);
        chk("rd_rvalid", e_rvalid, 1'b1);
        chk("rd_q", e_q, 8'h05);
        chk("rd_h_rvalid", h_rvalid, 1'b0);
        tick();
        @(negedge clk);
        chk("rd_late", e_rvalid, 1'b0);
        tick();

        if (CLR_EN) begin
            // Pre-clear host read, then clr_start colliding with requests.
            do_reset();
            e_req = 1'b1; e_wen = 1'b0; e_a = 10'h33; e_d = 8'h5A;
            @(negedge clk);
            chk("pc_wr_gnt", e_gnt, 1'b1);
            tick();
            e_req = 1'b0; h_req = 1'b1; h_wen = 1'b1; h_a = 10'h33;
            @(negedge clk);
            chk("pc_rd_gnt", h_gnt, 1'b1);
            tick();
            e_req = 1'b1; e_a = 10'h41; h_wen = 1'b0; h_a = 10'h40; h_d = 8'h77; clr_start = 1'b1;
            @(negedge clk);
            chk("clr_collide_gnt", {e_gnt, h_gnt}, 2'b00);
            tick();
            clr_start = 1'b0;
            busy_err = 0; gnt_err = 0; seq_err = 0; done_cnt = 0; done_at = 0;
            for (int i = 1; i <= 1030; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    chk("pc_h_rvalid", h_rvalid, 1'b1);
                    chk("pc_h_q", h_q, 8'h5A);
                end
                if (clr_busy !== (i <= 1024)) busy_err++;
                if (clr_busy && (e_gnt || h_gnt)) gnt_err++;
                if (i >= 2 && i <= 1025 && (sram_a !== 10'(i - 2) || sram_wen !== 1'b0 || sram_d !== 8'h00)) seq_err++;
                if (clr_done) begin
                    done_cnt++;
                    done_at = i;
                end
                tick();
            end
            chk("clr_busy_window", busy_err, 0);
            chk("clr_gnt_blocked", gnt_err, 0);
            chk("clr_write_seq", seq_err, 0);
            chk("clr_done_count", done_cnt, 1);
            chk("clr_done_cycle", done_at, 1025);

            // Reset asserted mid-clear at address 500.
            do_reset();
            e_req = 1'b1; h_req = 1'b1; e_wen = 1'b1; h_wen = 1'b1; clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
            found = 0;
            for (int i = 0; i < 2000 && found == 0; i++) begin
                @(negedge clk);
                if (clr_busy && sram_a == 10'd500) found = 1;
                else tick();
            end
            chk("mid_clr_reached", found, 1);
            reset = 1'b0;
            #1;
            chk("mr_sram", {sram_wen, sram_a, sram_d}, {1'b1, 10'h0, 8'h0});
            chk("mr_gnt", {e_gnt, h_gnt}, 2'b00);
            chk("mr_rvalid", {e_rvalid, h_rvalid}, 2'b00);
            chk("mr_q", {e_q, h_q}, 16'h0);
            chk("mr_clr", {clr_busy, clr_done}, 2'b00);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            done_cnt = 0; busy_err = 0;
            for (int i = 0; i < 1100; i++) begin
                @(negedge clk);
                if (clr_done) done_cnt++;
                if (clr_busy) busy_err++;
                tick();
            end
            chk("mr_no_done", done_cnt, 0);
            chk("mr_no_busy", busy_err, 0);
        end else begin
            // clr_start has no effect when the clear feature is not built.
            do_reset();
            e_req = 1'b1; e_wen = 1'b0; e_a = 10'h7; e_d = 8'h9; clr_start = 1'b1;
            err = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (e_gnt !== 1'b1 || h_gnt !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) err++;
                tick();
                clr_start = 1'b0;
            end
            chk("noclr_unaffected", err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/label_sram_arbiter.md
LABEL_SRAM_ARBITER -- requirements
Module: label_sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM address width (32x32 label map).
REQ-002 SHALL have parameter DATA_W, default 8, label width.
REQ-003 SHALL have parameter MAX_WAIT, default 8, consecutive host-wait cycles before a forced host grant (range 1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports e_req / e_wen / e_a / e_d, inputs, 1/1/ADDR_W/DATA_W: labeling-engine request, active-low write enable, address, write data.
REQ-007 SHALL have ports e_gnt / e_rvalid / e_q, outputs, 1/1/DATA_W: engine grant, read-data valid, read data.
REQ-008 SHALL have ports h_req / h_wen / h_a / h_d and h_gnt / h_rvalid / h_q, same widths: host readout port.
REQ-009 SHALL have ports sram_a / sram_d / sram_wen, outputs, ADDR_W/DATA_W/1, and sram_q, input, DATA_W.
REQ-010 SHALL have ports clr_start (in, 1), clr_busy (out, 1), clr_done (out, 1).

Function
REQ-011 SHALL implement FSM states IDLE, SERVE, CLEAR; IDLE->SERVE when any req is high; SERVE->IDLE when no req; IDLE/SERVE->CLEAR on clr_start; CLEAR->IDLE after last address.
REQ-012 SHALL grant at most one requester per cycle; grant is combinational (same cycle as req); the requester holds a/d/wen while req is high and treats req&gnt as one accepted access.
REQ-013 SHALL give the engine fixed priority, except that when the host wait counter equals MAX_WAIT the host is granted for exactly one cycle.
REQ-014 SHALL increment the host wait counter on each cycle with h_req high and h_gnt low, clear it on h_gnt, and saturate it at MAX_WAIT.
REQ-015 SHALL register the granted a/d/wen onto sram_a/sram_d/sram_wen at the posedge after acceptance; sram_wen is 1 (no write) in cycles with no grant.
REQ-016 SHALL, for an accepted read, assert the owner's rvalid with sram_q captured exactly 2 cycles after acceptance, and keep rvalid low at all other times.
REQ-017 SHALL return read data only to the requester that issued the read, using a 2-deep owner-tag pipeline.
REQ-018 SHALL in CLEAR write 0 to addresses 0..2^ADDR_W-1 in ascending order, one address per cycle, and deassert both grants.
REQ-019 SHALL hold clr_busy high throughout CLEAR and pulse clr_done high for one cycle on the cycle after the last write is issued.
REQ-020 SHALL ignore clr_start while in CLEAR; the clear address counter SHALL stop at its maximum and not wrap.
REQ-021 SHALL, when clr_start and requests arrive in the same cycle, grant no requester that cycle and enter CLEAR.
REQ-022 SHALL still deliver the rvalid of reads accepted before CLEAR entry.

Reset
REQ-023 SHALL on reset low force: state IDLE, sram_wen 1, sram_a 0, sram_d 0, all gnt/rvalid 0, e_q/h_q 0, clr_busy 0, clr_done 0, counters 0, tags empty.
REQ-024 SHALL abort CLEAR and discard in-flight reads when reset is asserted mid-operation; no clr_done follows.

Configuration
REQ-025 SHALL compile the CLEAR state, clr_* logic and clear counter only when LABEL_SRAM_CLEAR_EN is defined.
REQ-026 SHALL, without LABEL_SRAM_CLEAR_EN, keep clr_start as an unused input and tie clr_busy and clr_done to 0.

Structure
REQ-027 SHALL place the FSM state enum, owner-tag encoding (NONE/ENG/HOST) and default ADDR_W/DATA_W constants in package label_sram_pkg.
REQ-028 SHALL implement the priority/starvation grant logic as sub-module label_sram_grant; the datapath and FSM stay in the top module.

Verification
REQ-029 SHALL test: e_req and h_req both held high continuously, MAX_WAIT=8 -> h_gnt high on every 9th cycle, e_gnt high on all other cycles.
REQ-030 SHALL test: engine write of 8'h05 to address 10'h21, then engine read of 10'h21 -> e_rvalid high 2 cycles after read acceptance with e_q=8'h05; h_rvalid stays 0.
REQ-031 SHALL test: clr_start pulse -> clr_busy high for 1024 cycles, sram_a steps 0..1023 with sram_wen=0 and sram_d=0, one-cycle clr_done, and both grants 0 during CLEAR.
REQ-032 SHALL test: host read accepted one cycle before clr_start -> h_rvalid still asserted with the pre-clear data.
REQ-033 SHALL test: reset driven low at clear address 500 -> all outputs at reset values within the same cycle, and no clr_done after release.
REQ-034 SHALL test: build without LABEL_SRAM_CLEAR_EN and pulse clr_start -> clr_busy=0, clr_done=0, and arbitration unaffected.
